// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment decoder for the scanned seven-segment driver.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [6:0] seg7_t;

  // Active-low g..a pattern for one hex nibble.
  function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
    seg7_t seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot/digit/PWM counters for the scan driver, plus guard/active phase and frame pulse.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 100_000,
  parameter int unsigned GUARD      = 2000,
  localparam int unsigned SW        = $clog2(DWELL),
  localparam int unsigned DW        = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] dig_idx_o,
  output logic [3:0]    pwm_cnt_o,
  output logic          active_o,
  output logic          frame_start_o,
  output logic          frame_tick_o
);

  localparam logic [SW-1:0] SLOT_LAST = SW'(DWELL - 1);
  localparam logic [SW-1:0] GUARD_C   = SW'(GUARD);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [DW-1:0] dig_idx_q, dig_idx_d;
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  logic          frame_tick_q;
  logic          guard;
  logic          frame_start;

  always_comb begin
    slot_cnt_d = slot_cnt_q + SW'(1);
    dig_idx_d  = dig_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      dig_idx_d  = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + DW'(1);
    end
    // Clearing on the transition into slot_cnt==GUARD also covers GUARD==0.
    pwm_cnt_d   = (slot_cnt_d == GUARD_C) ? '0 : pwm_cnt_q + 4'd1;
    guard       = slot_cnt_q < GUARD_C;
    frame_start = (slot_cnt_q == '0) && (dig_idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= '0;
      pwm_cnt_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      frame_tick_q <= frame_start;
    end
  end

  assign dig_idx_o     = dig_idx_q;
  assign pwm_cnt_o     = pwm_cnt_q;
  assign active_o      = ~guard;
  assign frame_start_o = frame_start;
  assign frame_tick_o  = frame_tick_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver: frame shadowing, zero suppression,
// PWM brightness and registered anode/segment outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SCAN_HZ    = 1000,
  parameter int unsigned GUARD      = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              segment,
  output logic                    frame_tick
);

  localparam int unsigned DWELL = CLK_HZ / SCAN_HZ;
  localparam int unsigned DW    = $clog2(NUM_DIGITS);

  if (GUARD >= DWELL) begin : g_bad_guard
    $error("seg_scan_driver: GUARD must be less than CLK_HZ/SCAN_HZ");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_driver: NUM_DIGITS must be in 2..8");
  end

  logic [DW-1:0] dig_idx;
  logic [3:0]    pwm_cnt;
  logic          active;
  logic          frame_start;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DWELL      (DWELL),
    .GUARD      (GUARD)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .dig_idx_o     (dig_idx),
    .pwm_cnt_o     (pwm_cnt),
    .active_o      (active),
    .frame_start_o (frame_start),
    .frame_tick_o  (frame_tick)
  );

  logic [4*NUM_DIGITS-1:0] val_sh_q;
  logic [NUM_DIGITS-1:0]   dp_sh_q, en_sh_q;
  logic                    lz_sh_q;
  logic [3:0]              bri_sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_sh_q <= '0;
      dp_sh_q  <= '0;
      en_sh_q  <= '0;
      lz_sh_q  <= 1'b0;
      bri_sh_q <= '0;
    end else if (frame_start) begin
      val_sh_q <= value;
      dp_sh_q  <= dp;
      en_sh_q  <= digit_en;
      lz_sh_q  <= lz_blank;
      bri_sh_q <= brightness;
    end
  end

  logic [NUM_DIGITS-1:0] zblank;
  logic                  zrun;
  int unsigned           zidx;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  always_comb begin
    // A digit is zero-blanked while every nibble from it up to the MSD is zero.
    zblank = '0;
    zrun   = lz_sh_q;
    zidx   = 0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      zidx         = NUM_DIGITS - 1 - k;
      zrun         = zrun & (val_sh_q[4*zidx +: 4] == 4'h0);
      zblank[zidx] = zrun;
    end

    cur_nib = val_sh_q[{dig_idx, 2'b00} +: 4];
    cur_dp  = dp_sh_q[dig_idx];
    an_d    = '1;
    seg_d   = SEG_BLANK;
    if (active && (pwm_cnt <= bri_sh_q) && en_sh_q[dig_idx]) begin
      if (!zblank[dig_idx]) begin
        an_d[dig_idx] = 1'b0;
        seg_d         = {~cur_dp, hex_to_seg7(cur_nib)};
      end else if (cur_dp) begin
        an_d[dig_idx] = 1'b0;
        seg_d         = {1'b0, 7'h7F};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an      = an_q;
  assign segment = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DWELL=10, GUARD=2, four digits.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [3:0]  an;
  logic [7:0]  segment;
  logic        frame_tick;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  seg_scan_driver #(
    .NUM_DIGITS (4),
    .CLK_HZ     (1000),
    .SCAN_HZ    (100),
    .GUARD      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .an         (an),
    .segment    (segment),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Steps at least one cycle, then stops on the negedge showing frame_tick (bounded).
  task automatic wait_frame(input string name);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (frame_tick !== 1'b1)
      $display("FAIL %s wait_frame: frame_tick=%b, required 1 within 100 cycles", name, frame_tick);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (an !== 4'hF || segment !== 8'hFF || frame_tick !== 1'b0)
      $display("FAIL reset_state: an=%h seg=%h tick=%b, required an=f seg=ff tick=0", an, segment, frame_tick);
    else
      n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (frame_tick !== 1'b1 || an !== 4'hF || segment !== 8'hFF)
      $display("FAIL reset_first_tick: an=%h seg=%h tick=%b, required an=f seg=ff tick=1", an, segment, frame_tick);
    else
      n_pass++;
  endtask

  // Starts on the first frame_tick negedge after reset release.
  task automatic test_basic();
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int j = 0; j < 40; j++) begin
      int s, d;
      logic [3:0] ea;
      logic [7:0] es;
      s  = j % 10;
      d  = j / 10;
      ea = (s >= 2) ? an_tab[d] : 4'hF;
      es = (s >= 2) ? seg_tab[d] : 8'hFF;
      n_checks++;
      if (an !== ea || segment !== es || frame_tick !== (j == 0))
        $display("FAIL basic j=%0d: an=%b seg=%h tick=%b, required an=%b seg=%h tick=%b",
                 j, an, segment, frame_tick, ea, es, (j == 0));
      else
        n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (frame_tick !== 1'b1)
      $display("FAIL basic_period: tick=%b at cycle 40, required 1", frame_tick);
    else
      n_pass++;
  endtask

  task automatic test_lz_blank();
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    seg_tab = '{8'hC0, 8'h92, 8'h7F, 8'hFF};
    value = 16'h0050; lz_blank = 1'b1; dp = 4'b0100;
    wait_frame("lz");
    for (int j = 0; j < 40; j++) begin
      int s, d;
      logic [3:0] ea;
      logic [7:0] es;
      s  = j % 10;
      d  = j / 10;
      ea = (s >= 2) ? an_tab[d] : 4'hF;
      es = (s >= 2) ? seg_tab[d] : 8'hFF;
      n_checks++;
      if (an !== ea || segment !== es)
        $display("FAIL lz j=%0d: an=%b seg=%h, required an=%b seg=%h", j, an, segment, ea, es);
      else
        n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_midframe_shadow();
    logic [3:0] an_tab [4];
    logic [7:0] old_tab [4];
    logic [7:0] new_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    old_tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    new_tab = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    value = 16'h1234; lz_blank = 1'b0; dp = 4'h0;
    wait_frame("shadow");
    for (int j = 0; j < 80; j++) begin
      int s, d;
      logic [3:0] ea;
      logic [7:0] es;
      s  = j % 10;
      d  = (j / 10) % 4;
      ea = (s >= 2) ? an_tab[d] : 4'hF;
      es = (s >= 2) ? ((j < 40) ? old_tab[d] : new_tab[d]) : 8'hFF;
      n_checks++;
      if (an !== ea || segment !== es || frame_tick !== (j % 40 == 0))
        $display("FAIL shadow j=%0d: an=%b seg=%h tick=%b, required an=%b seg=%h tick=%b",
                 j, an, segment, frame_tick, ea, es, (j % 40 == 0));
      else
        n_pass++;
      if (j == 15) value = 16'hABCD;
      @(negedge clk);
    end
  endtask

  task automatic test_brightness();
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    value = 16'h1234; brightness = 4'd3;
    wait_frame("bright");
    for (int j = 0; j < 80; j++) begin
      int s, d, bri;
      logic lit;
      logic [3:0] ea;
      logic [7:0] es;
      s   = j % 10;
      d   = (j / 10) % 4;
      bri = (j < 40) ? 3 : 0;
      lit = (s >= 2) && (s - 2 <= bri);
      ea  = lit ? an_tab[d] : 4'hF;
      es  = lit ? seg_tab[d] : 8'hFF;
      n_checks++;
      if (an !== ea || segment !== es)
        $display("FAIL bright j=%0d: an=%b seg=%h, required an=%b seg=%h", j, an, segment, ea, es);
      else
        n_pass++;
      if (j == 5) brightness = 4'd0;
      @(negedge clk);
    end
  endtask

  task automatic test_digit_en();
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    an_tab  = '{4'b1111, 4'b1101, 4'b1111, 4'b0111};
    seg_tab = '{8'hFF, 8'hB0, 8'hFF, 8'hF9};
    brightness = 4'd15; digit_en = 4'b1010;
    wait_frame("enable");
    for (int j = 0; j < 40; j++) begin
      int s, d;
      logic [3:0] ea;
      logic [7:0] es;
      s  = j % 10;
      d  = j / 10;
      ea = (s >= 2) ? an_tab[d] : 4'hF;
      es = (s >= 2) ? seg_tab[d] : 8'hFF;
      n_checks++;
      if (an !== ea || segment !== es || frame_tick !== (j == 0))
        $display("FAIL enable j=%0d: an=%b seg=%h tick=%b, required an=%b seg=%h tick=%b",
                 j, an, segment, frame_tick, ea, es, (j == 0));
      else
        n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (frame_tick !== 1'b1)
      $display("FAIL enable_period: tick=%b at cycle 40, required 1", frame_tick);
    else
      n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    digit_en = 4'hF;
    wait_frame("rst_mid");
    for (int j = 0; j < 26; j++) begin
      int s, d;
      logic [3:0] ea;
      logic [7:0] es;
      s  = j % 10;
      d  = j / 10;
      ea = (s >= 2) ? an_tab[d] : 4'hF;
      es = (s >= 2) ? seg_tab[d] : 8'hFF;
      n_checks++;
      if (an !== ea || segment !== es)
        $display("FAIL rst_mid_pre j=%0d: an=%b seg=%h, required an=%b seg=%h", j, an, segment, ea, es);
      else
        n_pass++;
      if (j < 25) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'hF || segment !== 8'hFF || frame_tick !== 1'b0)
      $display("FAIL rst_mid_async: an=%b seg=%h tick=%b, required an=1111 seg=ff tick=0", an, segment, frame_tick);
    else
      n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 40; j++) begin
      int s, d;
      logic [3:0] ea;
      logic [7:0] es;
      s  = j % 10;
      d  = j / 10;
      ea = (s >= 2) ? an_tab[d] : 4'hF;
      es = (s >= 2) ? seg_tab[d] : 8'hFF;
      n_checks++;
      if (an !== ea || segment !== es || frame_tick !== (j == 0))
        $display("FAIL rst_mid_post j=%0d: an=%b seg=%h tick=%b, required an=%b seg=%h tick=%b",
                 j, an, segment, frame_tick, ea, es, (j == 0));
      else
        n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lz_blank();
    test_midframe_shadow();
    test_brightness();
    test_digit_en();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
